// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters and mispredict statistics.
// Lookup is combinational (0 cycles); training writes land next cycle; no backpressure.
module branch_predictor_btb #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lk_valid,
  input  logic [ADDR_W-1:0] lk_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_is_branch,
  input  logic              upd_is_jal,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic              flush_all,
  output logic [CNT_W-1:0]  stat_branches,
  output logic [CNT_W-1:0]  stat_mispred
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(1) << (CTR_W - 1);
  localparam logic [CTR_W-1:0] CTR_WNT = CTR_WT - CTR_W'(1);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [ADDR_W-1:0]  target_q [ENTRIES];
  logic [ENTRIES-1:0] jal_q;
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             train;
  logic             mispred;
  logic [CTR_W-1:0] ctr_cur;
  logic [CTR_W-1:0] ctr_nxt;

  logic unused_pc_lsb;
  assign unused_pc_lsb = &{1'b0, lk_pc[1:0], upd_pc[1:0]};

  assign lk_idx = lk_pc[IDX_W+1:2];
  assign lk_tag = lk_pc[ADDR_W-1:IDX_W+2];
  assign lk_hit = lk_valid & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);

  assign pred_taken  = lk_hit & (jal_q[lk_idx] | ctr_q[lk_idx][CTR_W-1]);
  assign pred_target = pred_taken ? target_q[lk_idx] : lk_pc + ADDR_W'(4);

  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[ADDR_W-1:IDX_W+2];
  assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  assign train   = upd_valid & (upd_is_branch | upd_is_jal);
  // A taken outcome with the wrong target is as costly as a wrong direction.
  assign mispred = (upd_pred_taken != upd_taken) |
                   (upd_taken & (upd_pred_target != upd_target));

  always_comb begin
    ctr_cur = ctr_q[upd_idx];
    ctr_nxt = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != '1) ctr_nxt = ctr_cur + CTR_W'(1);
    end else begin
      if (ctr_cur != '0) ctr_nxt = ctr_cur - CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q       <= '0;
      jal_q         <= '0;
      stat_branches <= '0;
      stat_mispred  <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else begin
      if (flush_all) begin
        valid_q <= '0;
      end else if (train) begin
        if (upd_hit) begin
          ctr_q[upd_idx] <= ctr_nxt;
          jal_q[upd_idx] <= upd_is_jal;
          if (upd_taken) target_q[upd_idx] <= upd_target;
        end else if (upd_taken) begin
          // Direct-mapped: a taken miss simply evicts whatever aliases here.
          valid_q[upd_idx]  <= 1'b1;
          tag_q[upd_idx]    <= upd_tag;
          target_q[upd_idx] <= upd_target;
          jal_q[upd_idx]    <= upd_is_jal;
          ctr_q[upd_idx]    <= CTR_WT;
        end
      end
      if (train) begin
        if (stat_branches != '1) stat_branches <= stat_branches + CNT_W'(1);
        if (mispred && stat_mispred != '1) stat_mispred <= stat_mispred + CNT_W'(1);
      end
    end
  end

endmodule
